// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Active-low g..a patterns for hex digits 0..F (lowercase b and d shapes).
  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment driver with blanking slots, per-digit masking
// and a shadow register that only commits new values on frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW  = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  scan_state_t             state_reg, state_next;
  logic [4*NUM_DIGITS-1:0] display_reg, shadow_reg;
  logic                    pending_reg;
  seg_t                    seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic                    frame_tick_reg;

  logic                    cnt_wrap;
  logic                    frame_end;
  logic                    accept;
  logic [3:0]              nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   digit_an;
  seg_t                    dec_seg;

  assign cnt_wrap  = (cnt_reg == CNT_LAST);
  assign frame_end = cnt_wrap && (idx_reg == IDX_LAST);
  assign accept    = load_valid && !pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibbles[gi]  = display_reg[4*gi +: 4];
      assign digit_an[gi] = (idx_reg != IW'(gi));
    end
  endgenerate

  seg7_hex_decode u_decode (
    .nibble (nibbles[idx_reg]),
    .seg    (dec_seg)
  );

  // Outputs are only recomputed when the scan state flips, so mask changes
  // land at the next SHOW entry rather than mid-slot.
  always_comb begin
    state_next = state_reg;
    seg_next   = seg_reg;
    an_next    = an_reg;
    case (state_reg)
      ST_BLANK: if (cnt_reg == CNT_SHOW) state_next = ST_SHOW;
      ST_SHOW:  if (cnt_wrap)            state_next = ST_BLANK;
      default:                           state_next = ST_BLANK;
    endcase
    if (state_next != state_reg) begin
      if (state_next == ST_SHOW && !blank_mask[idx_reg]) begin
        seg_next = dec_seg;
        an_next  = digit_an;
      end else begin
        seg_next = SEG_OFF;
        an_next  = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      state_reg <= ST_BLANK;
      seg_reg   <= SEG_OFF;
      an_reg    <= '1;
    end else begin
      state_reg <= state_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
      if (cnt_wrap) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  // A load accepted on the boundary edge itself only reaches the shadow,
  // so it waits a whole frame before being shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_reg    <= '0;
      shadow_reg     <= '0;
      pending_reg    <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_end;
      if (frame_end && pending_reg) begin
        display_reg <= shadow_reg;
        pending_reg <= 1'b0;
      end
      if (accept) begin
        shadow_reg  <= load_data;
        pending_reg <= 1'b1;
      end
    end
  end

  assign load_ready = !pending_reg;
  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  blank_mask = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [6:0] hex_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: m_n counts clock edges since reset release; slot position
  // and digit follow from it arithmetically.
  int          m_n;
  logic        m_pend;
  logic [15:0] m_shad, m_disp;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic        m_tick;
  logic [3:0]  cur_mask = '0;

  task automatic model_reset();
    m_n = 0; m_pend = 1'b0; m_shad = '0; m_disp = '0;
    m_seg = 7'h7F; m_an = 4'hF; m_tick = 1'b0;
  endtask

  task automatic model_edge(input logic lv, input logic [15:0] ld, input logic [3:0] bm);
    int   pos, dig;
    logic boundary, acc;
    pos      = m_n % RD;
    dig      = (m_n / RD) % ND;
    boundary = (pos == RD - 1) && (dig == ND - 1);
    acc      = lv && !m_pend;
    if (pos == BC - 1) begin
      if (bm[dig]) begin
        m_seg = 7'h7F; m_an = 4'hF;
      end else begin
        m_an = 4'hF; m_an[dig] = 1'b0;
        m_seg = hex_seg[m_disp[dig*4 +: 4]];
      end
    end else if (pos == RD - 1) begin
      m_seg = 7'h7F; m_an = 4'hF;
    end
    m_tick = boundary;
    if (boundary && m_pend) begin
      m_disp = m_shad; m_pend = 1'b0;
      $display("frame commit: display=%h at cycle %0d", m_shad, m_n);
    end
    if (acc) begin
      m_shad = ld; m_pend = 1'b1;
      $display("load accepted: data=%h at cycle %0d (digit %0d, cnt %0d)", ld, m_n, dig, pos);
    end
    m_n++;
  endtask

  task automatic compare();
    check("seg", seg, m_seg);
    check("an", an, m_an);
    check("load_ready", load_ready, !m_pend);
    check("frame_tick", frame_tick, m_tick);
    check("an_onehot", ($countones(~an) <= 1), 1);
  endtask

  // Called at a falling edge: drive, take one rising edge, check at next fall.
  task automatic cycle(input logic lv, input logic [15:0] ld, input logic [3:0] bm);
    load_valid = lv; load_data = ld; blank_mask = bm;
    @(posedge clk);
    model_edge(lv, ld, bm);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 16'($urandom), cur_mask);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME; i++) begin
      if ((m_n % FRAME) == p) break;
      idle(1);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      if (!m_pend) break;
      idle(1);
    end
    check("ready_timeout", load_ready, 1);
  endtask

  task automatic load_word(input logic [15:0] d);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      acc = !m_pend;
      cycle(1'b1, d, cur_mask);
      if (acc) break;
    end
    check("load_timeout", acc, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_ready", load_ready, 1);
    check("rst_tick", frame_tick, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Load during frame 0: frame 0 shows zeros, frame 1 shows 1234.
    cycle(1'b1, 16'h1234, cur_mask);
    idle(3);
    check("f0_seg", seg, 7'h40);
    check("f0_an", an, 4'hE);
    idle(32);
    check("f1_d0_seg", seg, 7'h19);
    check("f1_d0_an", an, 4'hE);
    wait_phase(28);
    check("f1_d3_seg", seg, 7'h79);
    check("f1_d3_an", an, 4'h7);
    idle(FRAME);

    // Back-to-back loads: second is held off until the first commits.
    wait_ready();
    cycle(1'b1, 16'h1111, cur_mask);
    check("b2b_ready_low", load_ready, 0);
    load_word(16'h2222);
    idle(3 * FRAME);

    // Masked digit 3, then unmask mid-frame.
    cur_mask = 4'b1000;
    wait_ready();
    load_word(16'hFEDC);
    wait_ready();
    wait_phase(28);
    check("mask_seg", seg, 7'h7F);
    check("mask_an", an, 4'hF);
    wait_phase(4);
    check("mask_d0_seg", seg, 7'h46);
    wait_phase(13);
    cur_mask = 4'b0000;
    wait_phase(28);
    check("unmask_seg", seg, 7'h0E);
    check("unmask_an", an, 4'h7);

    // Load exactly on the frame-boundary edge.
    wait_ready();
    wait_phase(31);
    cycle(1'b1, 16'hABCD, cur_mask);
    wait_phase(4);
    check("boundary_old_seg", seg, 7'h46);
    wait_phase(3);
    wait_phase(4);
    check("boundary_new_seg", seg, 7'h21);
    wait_phase(28);
    check("boundary_new_d3", seg, 7'h08);

    // Reset mid-slot with an update pending.
    wait_ready();
    wait_phase(17);
    cycle(1'b1, 16'h5678, cur_mask);
    wait_phase(21);
    do_reset();
    idle(FRAME + 4);
    check("post_rst_seg", seg, 7'h40);

    // Sweep every nibble through digit 0.
    for (int v = 0; v < 16; v++) begin
      wait_ready();
      load_word({12'h000, 4'(v)});
      wait_ready();
      wait_phase(4);
      check("sweep_seg", seg, hex_seg[v]);
    end

    // Random traffic.
    for (int i = 0; i < 1200; i++) begin
      if (($urandom % 16) == 0) cur_mask = 4'($urandom);
      cycle(($urandom % 4) == 0, 16'($urandom), cur_mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
